// File: rtl/fp_div.sv
// Multi-cycle IEEE-754 single-precision divider.
// Restoring mantissa division, guard-bit rounding, flag outputs.
module fp_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        done,
  output logic [31:0] Q,
  output logic        OF,
  output logic        UF,
  output logic        NanF,
  output logic        InfF,
  output logic        DNF,
  output logic        ZF,
  output logic        DZF
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASS,
    S_DIV,
    S_NORM,
    S_ROUND,
    S_PACK,
    S_DONE
  } state_t;

  state_t             r_st;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_s;
  logic signed [9:0]  r_e;
  logic [23:0]        r_mb;
  logic [25:0]        r_rem;
  logic [25:0]        r_q;
  logic [24:0]        r_m;
  logic               r_g;
  logic [4:0]         r_cnt;
  logic               r_spec;
  logic               r_nan;
  logic               r_inf;
  logic               r_dz;
  logic               r_z;
  logic               r_dnf;
  logic               r_done;
  logic [31:0]        r_qo;
  logic               r_of;
  logic               r_uf;
  logic               r_nanf;
  logic               r_inff;
  logic               r_dnff;
  logic               r_zf;
  logic               r_dzf;

  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic [22:0] w_fa;
  logic [22:0] w_fb;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_a_inf;
  logic        w_b_inf;
  logic        w_a_zero;
  logic        w_b_zero;
  logic        w_dn;
  logic        w_nan;
  logic        w_ge;
  logic [24:0] w_rsub;
  logic [24:0] w_mr;

  assign w_ea     = r_a[30:23];
  assign w_eb     = r_b[30:23];
  assign w_fa     = r_a[22:0];
  assign w_fb     = r_b[22:0];
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  // Denormal operands are flushed to zero.
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_dn     = (w_a_zero && (w_fa != 23'd0))
                 || (w_b_zero && (w_fb != 23'd0));
  assign w_nan    = w_a_nan || w_b_nan
                 || (w_a_zero && w_b_zero)
                 || (w_a_inf && w_b_inf);

  assign w_ge   = (r_rem >= {2'b00, r_mb});
  assign w_rsub = w_ge ? 25'(r_rem - {2'b00, r_mb})
                       : r_rem[24:0];
  assign w_mr   = r_m + {24'd0, r_g};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st   <= S_IDLE;
      r_a    <= '0;
      r_b    <= '0;
      r_s    <= 1'b0;
      r_e    <= '0;
      r_mb   <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_m    <= '0;
      r_g    <= 1'b0;
      r_cnt  <= '0;
      r_spec <= 1'b0;
      r_nan  <= 1'b0;
      r_inf  <= 1'b0;
      r_dz   <= 1'b0;
      r_z    <= 1'b0;
      r_dnf  <= 1'b0;
      r_done <= 1'b0;
      r_qo   <= '0;
      r_of   <= 1'b0;
      r_uf   <= 1'b0;
      r_nanf <= 1'b0;
      r_inff <= 1'b0;
      r_dnff <= 1'b0;
      r_zf   <= 1'b0;
      r_dzf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_st)
        S_IDLE: begin
          if (start) begin
            r_a  <= A;
            r_b  <= B;
            r_st <= S_CLASS;
          end
        end
        S_CLASS: begin
          r_s    <= r_a[31] ^ r_b[31];
          r_dnf  <= w_dn;
          r_spec <= 1'b1;
          r_nan  <= 1'b0;
          r_inf  <= 1'b0;
          r_dz   <= 1'b0;
          r_z    <= 1'b0;
          r_st   <= S_PACK;
          if (w_nan) begin
            r_nan <= 1'b1;
          end else if (w_a_inf) begin
            r_inf <= 1'b1;
          end else if (w_b_zero) begin
            r_inf <= 1'b1;
            r_dz  <= 1'b1;
          end else if (w_a_zero || w_b_inf) begin
            r_z <= 1'b1;
          end else begin
            r_spec <= 1'b0;
            r_rem  <= {3'b001, w_fa};
            r_mb   <= {1'b1, w_fb};
            r_q    <= '0;
            r_cnt  <= '0;
            r_e    <= $signed({2'b00, w_ea})
                    - $signed({2'b00, w_eb})
                    + 10'sd127;
            r_st   <= S_DIV;
          end
        end
        S_DIV: begin
          r_q   <= {r_q[24:0], w_ge};
          r_rem <= {w_rsub, 1'b0};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd25)
            r_st <= S_NORM;
        end
        S_NORM: begin
          if (r_q[25]) begin
            r_m <= {1'b0, r_q[25:2]};
            r_g <= r_q[1];
          end else begin
            r_m <= {1'b0, r_q[24:1]};
            r_g <= r_q[0];
            r_e <= r_e - 10'sd1;
          end
          r_st <= S_ROUND;
        end
        S_ROUND: begin
          if (w_mr[24]) begin
            r_m <= {1'b0, w_mr[24:1]};
            r_e <= r_e + 10'sd1;
          end else begin
            r_m <= w_mr;
          end
          r_st <= S_PACK;
        end
        S_PACK: begin
          r_done <= 1'b1;
          r_st   <= S_DONE;
          r_dnff <= r_dnf;
          r_nanf <= r_nan;
          r_inff <= r_inf;
          r_dzf  <= r_dz;
          r_zf   <= r_z;
          r_of   <= 1'b0;
          r_uf   <= 1'b0;
          if (r_spec) begin
            r_qo <= {r_s,
                     (r_nan || r_inf) ? 8'hFF : 8'h00,
                     r_nan ? 23'h7FFFFF : 23'd0};
          end else if (r_e >= 10'sd255) begin
            r_qo <= {r_s, 8'hFF, 23'd0};
            r_of <= 1'b1;
          end else if (r_e <= 10'sd0) begin
            r_qo <= {r_s, 31'd0};
            r_uf <= 1'b1;
          end else begin
            r_qo <= {r_s, r_e[7:0], r_m[22:0]};
          end
        end
        S_DONE: r_st <= S_IDLE;
        default: r_st <= S_IDLE;
      endcase
    end
  end

  assign done = r_done;
  assign Q    = r_qo;
  assign OF   = r_of;
  assign UF   = r_uf;
  assign NanF = r_nanf;
  assign InfF = r_inff;
  assign DNF  = r_dnff;
  assign ZF   = r_zf;
  assign DZF  = r_dzf;

endmodule
